// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the 1RW SRAM controller slice.
//   sram_state_e : controller FSM states (memory clear, normal operation)
//   mask_expand  : turns a lane write mask into a per-bit write enable vector
// mask_expand works on a fixed maximum width so one function serves every
// parameterisation; callers zero-extend the mask and keep the low WIDTH bits.
// -----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } sram_state_e;

    localparam int SRAM_MAX_W = 1024;
    localparam int SRAM_IDX_W = $clog2(SRAM_MAX_W);

    // Bit b of the result is mask bit (b / lane_w).
    function automatic logic [SRAM_MAX_W-1:0] mask_expand(
        input logic [SRAM_MAX_W-1:0] mask,
        input int unsigned           lane_w
    );
        logic [SRAM_MAX_W-1:0] en;
        en = {SRAM_MAX_W{1'b0}};
        for (int unsigned i = 0; i < SRAM_MAX_W; i++) begin
            en[SRAM_IDX_W'(i)] = mask[SRAM_IDX_W'(i / lane_w)];
        end
        return en;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// -----------------------------------------------------------------------------
// sram_rsp_fifo
// Show-ahead response FIFO: the head entry is presented on rsp_rdata while
// rsp_valid is high and is removed on rsp_valid && pop.
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   push         write push_data into the tail (ignored when full)
//   push_data    data to enqueue
//   pop          consumer takes the head entry (ignored when empty)
//   rsp_valid    FIFO not empty
//   rsp_rdata    head entry, zero while empty
//   count        current occupancy
// -----------------------------------------------------------------------------
module sram_rsp_fifo #(
    parameter  int WIDTH     = 8,
    parameter  int RSP_DEPTH = 2,
    localparam int PTR_W     = $clog2(RSP_DEPTH),
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] store_r [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    assign push_s    = push && (count_r != CNT_W'(RSP_DEPTH));
    assign pop_s     = pop && (count_r != CNT_W'(0));
    assign rsp_valid = (count_r != CNT_W'(0));
    assign count     = count_r;

    // Storage array; contents need no reset because rsp_rdata is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push_s) begin
            store_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; depth need not be a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_W'(RSP_DEPTH - 1)) ? PTR_W'(0) : wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(RSP_DEPTH - 1)) ? PTR_W'(0) : rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Head presentation; zero when empty so reset shows all-zero data.
    always_comb begin
        if (rsp_valid) begin
            rsp_rdata = store_r[rd_ptr_r];
        end else begin
            rsp_rdata = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/sram_1rw_ctrl.sv
// -----------------------------------------------------------------------------
// sram_1rw_ctrl
// Single-port synchronous SRAM model with a valid/ready request front end,
// lane write masks, a post-reset clear of every word, and a credit-limited
// response FIFO so the consumer can backpressure read data.
// Ports:
//   CE, RST                clock, synchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_we                 1 = write, 0 = read
//   req_addr               word address (>= DEPTH: write dropped, read gives 0)
//   req_wdata, req_wmask   write data and lane enables
//   rsp_valid/rsp_ready    read response handshake
//   rsp_rdata              read data (held while rsp_valid && !rsp_ready)
//   busy                   high while the clear sequence runs
// Build option: define SRAM_OUT_REG_EN to add an output register after the
// array (read latency 2 instead of 1); the credit rule covers that stage.
// -----------------------------------------------------------------------------
module sram_1rw_ctrl
    import sram_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 128,
    parameter  int LANE_W    = 8,
    parameter  int RSP_DEPTH = 2,
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int MASK_W    = WIDTH / LANE_W
) (
    input  logic              CE,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OUT_W = CNT_W + 1;

    sram_state_e            state_r;
    logic [ADDR_W-1:0]      clr_addr_r;
    logic [WIDTH-1:0]       mem_r [DEPTH];

    logic                   run_s;
    logic                   in_range_s;
    logic                   credit_ok_s;
    logic                   rd_acc_s;
    logic                   wr_acc_s;
    logic [SRAM_MAX_W-1:0]  mask_wide_s;
    logic [SRAM_MAX_W-1:0]  ben_wide_s;
    logic                   unused_ben_s;
    logic [WIDTH-1:0]       bit_en_s;
    logic [WIDTH-1:0]       rd_word_s;
    logic                   fifo_push_s;
    logic [WIDTH-1:0]       fifo_wdata_s;
    logic [CNT_W-1:0]       fifo_count_s;
    logic                   inflight_s;
    logic [OUT_W-1:0]       outstanding_s;

    assign run_s      = (state_r == ST_RUN);
    assign busy       = ~run_s;
    assign in_range_s = ({{(32 - ADDR_W){1'b0}}, req_addr} < 32'(DEPTH));

    // Credits come only from registered state, so a pop frees its credit one
    // cycle later and rsp_ready never reaches req_ready combinationally.
    // Writes never consume a credit.
    assign outstanding_s = {1'b0, fifo_count_s} + OUT_W'(inflight_s);
    assign credit_ok_s   = (outstanding_s < OUT_W'(RSP_DEPTH));
    assign req_ready     = run_s && (req_we || credit_ok_s);
    assign rd_acc_s      = req_valid && req_ready && !req_we;
    assign wr_acc_s      = req_valid && req_ready && req_we;

    // Lane mask to per-bit enables through the shared helper.
    always_comb begin
        mask_wide_s                = {SRAM_MAX_W{1'b0}};
        mask_wide_s[MASK_W-1:0]    = req_wmask;
        ben_wide_s                 = mask_expand(mask_wide_s, LANE_W);
    end
    assign bit_en_s     = ben_wide_s[WIDTH-1:0];
    assign unused_ben_s = ^ben_wide_s;

    // Array read port; out-of-range reads return zero.
    always_comb begin
        if (in_range_s) begin
            rd_word_s = mem_r[req_addr];
        end else begin
            rd_word_s = {WIDTH{1'b0}};
        end
    end

    // Controller FSM: RST restarts the clear from word 0 in any state.
    always_ff @(posedge CE) begin
        if (RST) begin
            state_r    <= ST_CLEAR;
            clr_addr_r <= ADDR_W'(0);
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_addr_r == ADDR_W'(DEPTH - 1)) begin
                        state_r <= ST_RUN;
                    end else begin
                        clr_addr_r <= clr_addr_r + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r    <= ST_CLEAR;
                    clr_addr_r <= ADDR_W'(0);
                end
            endcase
        end
    end

    // Memory array: clear writes during CLEAR, masked request writes in RUN.
    always_ff @(posedge CE) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_addr_r] <= {WIDTH{1'b0}};
        end else if (wr_acc_s && in_range_s) begin
            mem_r[req_addr] <= (mem_r[req_addr] & ~bit_en_s) | (req_wdata & bit_en_s);
        end
    end

`ifdef SRAM_OUT_REG_EN
    logic             pipe_vld_r;
    logic [WIDTH-1:0] pipe_data_r;

    // Output register stage between the array and the response FIFO.
    always_ff @(posedge CE) begin
        if (RST) begin
            pipe_vld_r  <= 1'b0;
            pipe_data_r <= {WIDTH{1'b0}};
        end else begin
            pipe_vld_r  <= rd_acc_s;
            pipe_data_r <= rd_word_s;
        end
    end

    assign fifo_push_s  = pipe_vld_r;
    assign fifo_wdata_s = pipe_data_r;
    assign inflight_s   = pipe_vld_r;
`else
    assign fifo_push_s  = rd_acc_s;
    assign fifo_wdata_s = rd_word_s;
    assign inflight_s   = 1'b0;
`endif

    sram_rsp_fifo #(
        .WIDTH     (WIDTH),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (CE),
        .rst       (RST),
        .push      (fifo_push_s),
        .push_data (fifo_wdata_s),
        .pop       (rsp_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .count     (fifo_count_s)
    );

endmodule

// File: tb/tb_sram_1rw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_1rw_ctrl
// Self-checking bench for sram_1rw_ctrl (WIDTH=32, DEPTH=100, RSP_DEPTH=2).
// A reference model tracks memory contents, the clear countdown and a queue
// of pending responses each tagged with the cycle it becomes visible.
// -----------------------------------------------------------------------------
module tb_sram_1rw_ctrl;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 100;
    localparam int LANE_W    = 8;
    localparam int RSP_DEPTH = 2;
    localparam int ADDR_W    = $clog2(DEPTH);
    localparam int MASK_W    = WIDTH / LANE_W;
`ifdef SRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              CE = 1'b0;
    logic              RST = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [WIDTH-1:0]  req_wdata = '0;
    logic [MASK_W-1:0] req_wmask = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [WIDTH-1:0]  rsp_rdata;
    logic              busy;

    sram_1rw_ctrl #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .LANE_W    (LANE_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .CE        (CE),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .busy      (busy)
    );

    always #5 CE = ~CE;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               vis;
    } rsp_t;

    logic [WIDTH-1:0] mdl_mem [DEPTH];
    rsp_t             mdl_q[$];
    int               clear_left = DEPTH;
    int               cyc_n = 0;
    bit               known = 1'b0;
    logic [WIDTH-1:0] got_q[$];
    bit               last_acc;
    bit               obs_valid;
    bit               obs_busy;
    logic [WIDTH-1:0] obs_rdata;
    int               n_tests = 0;
    int               n_fail = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs mid-cycle, then advance the model.
    task automatic cyc(input bit v, input bit we, input int addr, input logic [WIDTH-1:0] wd,
                       input logic [MASK_W-1:0] m, input bit rr, input bit rst);
        bit exp_busy;
        bit exp_ready;
        bit exp_valid;
        bit pop;
        req_valid = v;
        req_we    = we;
        req_addr  = ADDR_W'(addr);
        req_wdata = wd;
        req_wmask = m;
        rsp_ready = rr;
        RST       = rst;
        @(negedge CE);
        exp_busy  = (clear_left > 0);
        exp_ready = !exp_busy && (we || (mdl_q.size() < RSP_DEPTH));
        exp_valid = (mdl_q.size() > 0) && (mdl_q[0].vis <= cyc_n);
        obs_valid = rsp_valid;
        obs_busy  = busy;
        obs_rdata = rsp_rdata;
        if (known) begin
            check_val("busy", 64'(busy), 64'(exp_busy));
            check_val("req_ready", 64'(req_ready), 64'(exp_ready));
            check_val("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
            if (exp_valid) begin
                check_val("rsp_rdata", 64'(rsp_rdata), 64'(mdl_q[0].d));
            end
        end
        last_acc = v && exp_ready && !rst;
        pop      = exp_valid && rr && !rst;
        if (pop && rsp_valid) begin
            got_q.push_back(rsp_rdata);
        end
        @(posedge CE);
        if (rst) begin
            mdl_q.delete();
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
            known = 1'b1;
        end else begin
            if (pop) void'(mdl_q.pop_front());
            if (clear_left > 0) begin
                clear_left--;
            end else if (last_acc) begin
                if (we) begin
                    if (addr < DEPTH) begin
                        for (int l = 0; l < MASK_W; l++) begin
                            if (m[l]) mdl_mem[addr][l*LANE_W +: LANE_W] = wd[l*LANE_W +: LANE_W];
                        end
                    end
                end else begin
                    rsp_t e;
                    e.d   = (addr < DEPTH) ? mdl_mem[addr] : '0;
                    e.vis = cyc_n + LAT;
                    mdl_q.push_back(e);
                end
            end
        end
        cyc_n++;
        #1;
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, '0, '0, rr, 1'b0);
    endtask

    task automatic wr(input int addr, input logic [WIDTH-1:0] d, input logic [MASK_W-1:0] m);
        cyc(1'b1, 1'b1, addr, d, m, 1'b1, 1'b0);
    endtask

    task automatic rd(input int addr, input bit rr);
        cyc(1'b1, 1'b0, addr, '0, '0, rr, 1'b0);
    endtask

    initial begin
        int nbusy;
        int acc_pat;
        int t0;
        int first;
        int c;

        // 1. Reset then clear: busy for exactly DEPTH cycles; cleared word reads 0.
        cyc(1'b0, 1'b0, 0, '0, '0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 0, '0, '0, 1'b0, 1'b1);
        check_val("reset_rdata", 64'(obs_rdata), 64'h0);
        check_val("reset_busy", 64'(obs_busy), 64'h1);
        nbusy = 0;
        for (int i = 0; i < DEPTH + 5; i++) begin
            idle(1, 1'b1);
            if (obs_busy) nbusy++;
        end
        check_val("clear_cycles", 64'(nbusy), 64'(DEPTH));
        got_q.delete();
        rd(DEPTH - 1, 1'b1);
        idle(4, 1'b1);
        check_val("clear_rd_count", 64'(got_q.size()), 64'h1);
        check_val("clear_rd_data", 64'(got_q[0]), 64'h0);

        // 2. Masked write merges lanes.
        got_q.delete();
        wr(5, 32'hDEADBEEF, 4'b1111);
        wr(5, 32'h11223344, 4'b0101);
        wr(5, 32'hFFFFFFFF, 4'b0000);
        rd(5, 1'b1);
        idle(4, 1'b1);
        check_val("mask_rd_data", 64'(got_q[0]), 64'hDE22BE44);

        // 3. Backpressure: two credits, third read waits for the first pop.
        wr(1, 32'h00000101, 4'b1111);
        wr(2, 32'h00000202, 4'b1111);
        wr(3, 32'h00000303, 4'b1111);
        got_q.delete();
        acc_pat = 0;
        rd(1, 1'b0); acc_pat = acc_pat * 2 + int'(last_acc);
        rd(2, 1'b0); acc_pat = acc_pat * 2 + int'(last_acc);
        rd(3, 1'b0); acc_pat = acc_pat * 2 + int'(last_acc);
        rd(3, 1'b1); acc_pat = acc_pat * 2 + int'(last_acc);
        rd(3, 1'b1); acc_pat = acc_pat * 2 + int'(last_acc);
        idle(6, 1'b1);
        check_val("bp_accept_pattern", 64'(acc_pat), 64'b11001);
        check_val("bp_rsp_count", 64'(got_q.size()), 64'h3);
        check_val("bp_order_0", 64'(got_q[0]), 64'h101);
        check_val("bp_order_1", 64'(got_q[1]), 64'h202);
        check_val("bp_order_2", 64'(got_q[2]), 64'h303);

        // 6. Read latency from acceptance to first rsp_valid.
        t0 = cyc_n;
        rd(2, 1'b0);
        check_val("lat_accept", 64'(last_acc), 64'h1);
        first = -1;
        for (int i = 0; i < 5; i++) begin
            c = cyc_n;
            idle(1, 1'b0);
            if (first < 0 && obs_valid) first = c;
        end
        check_val("read_latency", 64'(first - t0), 64'(LAT));
        idle(4, 1'b1);

        // 5. Out-of-range: write dropped, read yields zero, neighbour intact.
        got_q.delete();
        wr(99, 32'h12345678, 4'b1111);
        wr(110, 32'h000000AA, 4'b1111);
        rd(110, 1'b1);
        rd(99, 1'b1);
        idle(5, 1'b1);
        check_val("oor_rsp_count", 64'(got_q.size()), 64'h2);
        check_val("oor_rd_data", 64'(got_q[0]), 64'h0);
        check_val("oor_neighbour", 64'(got_q[1]), 64'h12345678);

        // 4. Reset with reads outstanding: stale responses never appear.
        rd(1, 1'b0);
        rd(2, 1'b0);
        got_q.delete();
        cyc(1'b0, 1'b0, 0, '0, '0, 1'b0, 1'b1);
        idle(1, 1'b1);
        check_val("rst_mid_valid", 64'(obs_valid), 64'h0);
        check_val("rst_mid_busy", 64'(obs_busy), 64'h1);
        idle(DEPTH + 3, 1'b1);
        check_val("rst_mid_stale", 64'(got_q.size()), 64'h0);
        rd(1, 1'b1);
        idle(4, 1'b1);
        check_val("rst_mid_cleared", 64'(got_q[0]), 64'h0);

        // Randomised traffic against the model, with rare resets.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, DEPTH + 15)), WIDTH'($urandom),
                MASK_W'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 299) == 0));
        end
        idle(6, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
